// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   ctrlState_e : controller states (RUN / MISS / MULT)
//   ctrlOut_t   : bundle of pipeline control outputs
//   CTL_*       : canned output patterns used by the controller
package pipe_hazard_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN  = 2'd0,
      MISS = 2'd1,
      MULT = 2'd2
   } ctrlState_e;

   localparam int MULT_LAT_DEF = 32;
   localparam int MULT_CNT_W   = 6;
   localparam logic [15:0] STALL_MAX = 16'hFFFF;

   typedef struct packed {
      logic pcEn;
      logic ifidEn;
      logic ifidFlush;
      logic idexEn;
      logic idexBubble;
      logic multStart;
   } ctrlOut_t;

   // Everything frozen, nothing flushed.
   localparam ctrlOut_t CTL_FREEZE = '{pcEn: 1'b0, ifidEn: 1'b0, ifidFlush: 1'b0,
                                       idexEn: 1'b0, idexBubble: 1'b0, multStart: 1'b0};
   // Pipeline advances normally.
   localparam ctrlOut_t CTL_ADVANCE = '{pcEn: 1'b1, ifidEn: 1'b1, ifidFlush: 1'b0,
                                        idexEn: 1'b1, idexBubble: 1'b0, multStart: 1'b0};
   // Held in reset: frozen with IF/ID and ID/EX cleared.
   localparam ctrlOut_t CTL_RESET = '{pcEn: 1'b0, ifidEn: 1'b0, ifidFlush: 1'b1,
                                      idexEn: 1'b0, idexBubble: 1'b1, multStart: 1'b0};

endpackage

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// load_use_detect: pure combinational load-use hazard check.
//   memRead : instruction in ID/EX is a load
//   exRt    : destination (rt) of the load in ID/EX
//   idRs    : rs of the instruction in IF/ID
//   idRt    : rt of the instruction in IF/ID
//   hazard  : IF/ID consumer needs the load result next cycle
module load_use_detect (
   input  logic       memRead,
   input  logic [4:0] exRt,
   input  logic [4:0] idRs,
   input  logic [4:0] idRt,
   output logic       hazard
);

   // $zero is never a real dependency.
   assign hazard = memRead && (exRt != 5'd0) && ((exRt == idRs) || (exRt == idRt));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush controller for a 5-stage pipeline with a
// multi-cycle Booth multiplier and blocking I/D caches.
//   clk, rst_n          : clock, async active-low reset
//   id_rs, id_rt        : source fields of the IF/ID instruction
//   idex_memread/_rt    : load info held in ID/EX
//   idex_mult           : ID/EX holds a multiply
//   branch_taken        : resolved taken branch (EX/MEM)
//   icache_hit/dcache_hit : cache hit flags
//   pc_en, ifid_en, idex_en : stage load enables
//   ifid_flush, idex_bubble : zero IF/ID, squash ID/EX control
//   mult_start          : one-cycle multiplier start pulse
//   stall_cycles        : saturating count of cycles with pc_en=0
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int MULT_LAT = MULT_LAT_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic        idex_memread,
   input  logic [4:0]  idex_rt,
   input  logic        idex_mult,
   input  logic        branch_taken,
   input  logic        icache_hit,
   input  logic        dcache_hit,
   output logic        pc_en,
   output logic        ifid_en,
   output logic        ifid_flush,
   output logic        idex_en,
   output logic        idex_bubble,
   output logic        mult_start,
   output logic [15:0] stall_cycles
);

   // Start cycle already stalls once, so the counter covers the remainder.
   localparam logic [MULT_CNT_W-1:0] MULT_LOAD = MULT_CNT_W'(MULT_LAT - 1);

   ctrlState_e            state, stateNxt;
   logic [MULT_CNT_W-1:0] multCnt, multCntNxt;
   logic [15:0]           stallCnt;
   ctrlOut_t              ctl;
   logic                  cacheMiss, loadUse;

   assign cacheMiss = !icache_hit || !dcache_hit;

   load_use_detect uLoadUse (
      .memRead (idex_memread),
      .exRt    (idex_rt),
      .idRs    (id_rs),
      .idRt    (id_rt),
      .hazard  (loadUse)
   );

   // Outputs are combinational so the pipeline registers see them before
   // their negedge capture. Branch/mult/load-use are only looked at in RUN:
   // while frozen, the same instructions are still sitting in the stages.
   always_comb begin
      ctl        = CTL_FREEZE;
      stateNxt   = state;
      multCntNxt = multCnt;
      unique case (state)
         RUN: begin
            if (cacheMiss) begin
               stateNxt = MISS;
            end else if (branch_taken) begin
               ctl            = CTL_ADVANCE;
               ctl.ifidFlush  = 1'b1;
               ctl.idexBubble = 1'b1;
            end else if (idex_mult) begin
               ctl.multStart = 1'b1;
               multCntNxt    = MULT_LOAD;
               stateNxt      = MULT;
            end else if (loadUse) begin
               ctl.idexEn     = 1'b1;
               ctl.idexBubble = 1'b1;
            end else begin
               ctl = CTL_ADVANCE;
            end
         end
         // Exit cycle still stalls: the refill lands this cycle.
         MISS: if (!cacheMiss) stateNxt = RUN;
         // Release cycle advances ID/EX so the multiply is not restarted.
         MULT: begin
            if (multCnt == '0) begin
               ctl      = CTL_ADVANCE;
               stateNxt = RUN;
            end else begin
               multCntNxt = multCnt - 1'b1;
            end
         end
         default: stateNxt = RUN;
      endcase
      if (!rst_n) ctl = CTL_RESET;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= RUN;
         multCnt  <= '0;
         stallCnt <= '0;
      end else begin
         state   <= stateNxt;
         multCnt <= multCntNxt;
         if (!ctl.pcEn && (stallCnt != STALL_MAX)) stallCnt <= stallCnt + 16'd1;
      end
   end

   assign pc_en        = ctl.pcEn;
   assign ifid_en      = ctl.ifidEn;
   assign ifid_flush   = ctl.ifidFlush;
   assign idex_en      = ctl.idexEn;
   assign idex_bubble  = ctl.idexBubble;
   assign mult_start   = ctl.multStart;
   assign stall_cycles = stallCnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed stimulus, a cycle-level reference
// model checked on every negedge, and literal expectations at key points.
// Control vectors are packed {pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, mult_start}.
module tb_pipe_hazard_ctrl;

   localparam int MULT_LAT = 32;

   localparam logic [5:0] V_RST    = 6'b001010;
   localparam logic [5:0] V_NORM   = 6'b110100;
   localparam logic [5:0] V_FLUSH  = 6'b111110;
   localparam logic [5:0] V_LU     = 6'b000110;
   localparam logic [5:0] V_START  = 6'b000001;
   localparam logic [5:0] V_FREEZE = 6'b000000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [4:0]  id_rs = 5'd1, id_rt = 5'd2, idex_rt = 5'd0;
   logic        idex_memread = 1'b0, idex_mult = 1'b0, branch_taken = 1'b0;
   logic        icache_hit = 1'b1, dcache_hit = 1'b1;
   logic        pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, mult_start;
   logic [15:0] stall_cycles;
   logic [5:0]  dutCtl;

   int nChecks = 0, nFails = 0;
   // Reference model state: cycles left in an active multiply (incl. release),
   // whether a miss is outstanding, and the unsaturated stall count.
   int mMultLeft = 0, mStall = 0, startPulses = 0;
   bit mInMiss = 1'b0;

   pipe_hazard_ctrl #(.MULT_LAT(MULT_LAT)) dut (
      .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
      .idex_memread(idex_memread), .idex_rt(idex_rt), .idex_mult(idex_mult),
      .branch_taken(branch_taken), .icache_hit(icache_hit), .dcache_hit(dcache_hit),
      .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_en(idex_en),
      .idex_bubble(idex_bubble), .mult_start(mult_start), .stall_cycles(stall_cycles)
   );

   assign dutCtl = {pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, mult_start};

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Reference model and per-cycle compare.
   always @(negedge clk) begin
      logic [5:0] exp;
      logic       miss, lu;
      int         satStall;
      if (!rst_n) begin
         exp       = V_RST;
         mMultLeft = 0;
         mInMiss   = 1'b0;
         mStall    = 0;
      end else begin
         miss = !icache_hit || !dcache_hit;
         lu   = idex_memread && (idex_rt != 0) && (idex_rt == id_rs || idex_rt == id_rt);
         if (mMultLeft > 0) begin
            exp = (mMultLeft == 1) ? V_NORM : V_FREEZE;
            mMultLeft--;
         end else if (mInMiss) begin
            exp     = V_FREEZE;
            mInMiss = miss;
         end else if (miss) begin
            exp     = V_FREEZE;
            mInMiss = 1'b1;
         end else if (branch_taken) begin
            exp = V_FLUSH;
         end else if (idex_mult) begin
            exp       = V_START;
            mMultLeft = MULT_LAT;
         end else if (lu) begin
            exp = V_LU;
         end else begin
            exp = V_NORM;
         end
      end
      check("ctl_vs_model", {26'd0, dutCtl}, {26'd0, exp});
      satStall = (mStall > 65535) ? 65535 : mStall;
      check("stall_vs_model", {16'd0, stall_cycles}, satStall);
      if (rst_n && !exp[5]) mStall++;
      if (mult_start) startPulses++;
   end

   initial begin
      int s0, p0;
      // Reset values while held.
      #2;
      check("rst_ctl", {26'd0, dutCtl}, {26'd0, V_RST});
      check("rst_stall", {16'd0, stall_cycles}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      cyc(2);
      check("normal", {26'd0, dutCtl}, {26'd0, V_NORM});

      // Load-use: one stall cycle, then normal; rt=0 never stalls.
      s0 = stall_cycles;
      idex_memread = 1'b1; idex_rt = 5'd5; id_rs = 5'd5;
      #1 check("lu_stall", {26'd0, dutCtl}, {26'd0, V_LU});
      cyc(1);
      idex_memread = 1'b0;
      #1 check("lu_after", {26'd0, dutCtl}, {26'd0, V_NORM});
      check("lu_stall_cnt", stall_cycles - s0, 32'd1);
      cyc(1);
      idex_memread = 1'b1; idex_rt = 5'd0; id_rs = 5'd0;
      #1 check("lu_rt0", {26'd0, dutCtl}, {26'd0, V_NORM});
      cyc(1);
      idex_memread = 1'b0; id_rs = 5'd1;

      // Multiply: one start pulse, MULT_LAT stalled cycles, then release.
      s0 = stall_cycles; p0 = startPulses;
      idex_mult = 1'b1;
      #1 check("mult_start", {26'd0, dutCtl}, {26'd0, V_START});
      cyc(1);
      check("mult_frozen", {26'd0, dutCtl}, {26'd0, V_FREEZE});
      cyc(MULT_LAT - 1);
      check("mult_release", {26'd0, dutCtl}, {26'd0, V_NORM});
      cyc(1);
      idex_mult = 1'b0;
      #1 check("mult_after", {26'd0, dutCtl}, {26'd0, V_NORM});
      check("mult_stall_cnt", stall_cycles - s0, 32'd32);
      check("mult_pulses", startPulses - p0, 32'd1);

      // Miss of 4 cycles with a taken branch held: 5 stalled cycles, one flush.
      s0 = stall_cycles;
      dcache_hit = 1'b0; branch_taken = 1'b1;
      #1 check("miss_enter", {26'd0, dutCtl}, {26'd0, V_FREEZE});
      cyc(4);
      dcache_hit = 1'b1;
      #1 check("miss_exit_cycle", {26'd0, dutCtl}, {26'd0, V_FREEZE});
      cyc(1);
      check("miss_then_flush", {26'd0, dutCtl}, {26'd0, V_FLUSH});
      check("miss_stall_cnt", stall_cycles - s0, 32'd5);
      cyc(1);
      branch_taken = 1'b0;
      #1 check("flush_once", {26'd0, dutCtl}, {26'd0, V_NORM});

      // Simultaneous: branch beats mult and load-use; a miss beats everything.
      cyc(1);
      p0 = startPulses;
      branch_taken = 1'b1; idex_mult = 1'b1;
      idex_memread = 1'b1; idex_rt = 5'd5; id_rs = 5'd5;
      #1 check("simul_flush", {26'd0, dutCtl}, {26'd0, V_FLUSH});
      cyc(1);
      icache_hit = 1'b0;
      #1 check("simul_miss", {26'd0, dutCtl}, {26'd0, V_FREEZE});
      cyc(1);
      icache_hit = 1'b1; branch_taken = 1'b0; idex_mult = 1'b0; idex_memread = 1'b0;
      #1 check("simul_miss_exit", {26'd0, dutCtl}, {26'd0, V_FREEZE});
      cyc(1);
      check("simul_normal", {26'd0, dutCtl}, {26'd0, V_NORM});
      check("simul_no_start", startPulses - p0, 32'd0);

      // Reset mid-multiply (counter at 10): immediate reset outputs.
      idex_mult = 1'b1;
      cyc(22);
      #2 rst_n = 1'b0;
      #1 check("async_rst_ctl", {26'd0, dutCtl}, {26'd0, V_RST});
      check("async_rst_stall", {16'd0, stall_cycles}, 32'd0);
      idex_mult = 1'b0;
      cyc(2);
      rst_n = 1'b1;
      p0 = startPulses;
      cyc(1);
      check("post_rst_ctl", {26'd0, dutCtl}, {26'd0, V_NORM});
      check("post_rst_stall", {16'd0, stall_cycles}, 32'd0);
      check("post_rst_no_start", startPulses - p0, 32'd0);

      // Saturation: 70000 stalled cycles.
      icache_hit = 1'b0;
      cyc(70000);
      check("stall_sat", {16'd0, stall_cycles}, 32'h0000FFFF);
      icache_hit = 1'b1;
      cyc(3);
      check("stall_sat_hold", {16'd0, stall_cycles}, 32'h0000FFFF);
      check("sat_normal", {26'd0, dutCtl}, {26'd0, V_NORM});

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 The block SHALL have parameter MULT_LAT, default 32: cycles a Booth multiply occupies EX (legal range 2..63).
REQ-002 The block SHALL have the following ports, one per line as name, direction, width, meaning:
  clk  in  1  single clock; state updates on posedge; outputs stable before the pipeline registers' negedge capture.
  rst_n  in  1  asynchronous, active-low reset.
  id_rs  in  5  rs field of the instruction in IF/ID.
  id_rt  in  5  rt field of the instruction in IF/ID.
  idex_memread  in  1  MemRead held in ID/EX.
  idex_rt  in  5  rt held in ID/EX.
  idex_mult  in  1  ID/EX holds a multiply.
  branch_taken  in  1  resolved taken branch from EX/MEM.
  icache_hit  in  1  instruction cache hit.
  dcache_hit  in  1  data cache hit.
  pc_en  out  1  PC load enable.
  ifid_en  out  1  IF/ID load enable.
  ifid_flush  out  1  zero IF/ID.
  idex_en  out  1  drives the ID/EX "hit" enable.
  idex_bubble  out  1  force ID/EX control fields to zero.
  mult_start  out  1  one-cycle start pulse to the Booth multiplier.
  stall_cycles  out  16  saturating count of cycles with pc_en=0.

Function
REQ-003 The block SHALL implement an FSM with states RUN, MISS and MULT.
REQ-004 The block SHALL evaluate RUN conditions in strict priority order: miss > branch > mult > load-use > normal.
REQ-005 The block SHALL treat a miss in RUN as (!icache_hit || !dcache_hit): pc_en, ifid_en and idex_en SHALL be 0, all flushes 0, and next state MISS.
REQ-006 The block SHALL handle branch_taken=1 in RUN (no miss) as: all enables 1, ifid_flush=1, idex_bubble=1, state stays RUN.
REQ-007 The block SHALL handle idex_mult=1 in RUN (no miss, no branch) as: all enables 0, mult_start=1, counter loaded with MULT_LAT-1, next state MULT.
REQ-008 The block SHALL detect load-use in RUN as idex_memread && idex_rt!=0 && (idex_rt==id_rs || idex_rt==id_rt), and respond with pc_en=0, ifid_en=0, idex_en=1, idex_bubble=1, state stays RUN; no state is added.
REQ-009 The block SHALL, in RUN with no condition, drive all enables 1 and all flush/bubble outputs 0.
REQ-010 The block SHALL, in MISS, drive all enables 0; once icache_hit && dcache_hit, next state SHALL be RUN, giving a penalty of miss duration + 1 cycle.
REQ-011 The block SHALL, in MULT, drive all enables 0 and decrement the counter each cycle; at counter==0 it SHALL drive all enables 1 for that cycle (release) and return to RUN, so a multiply stalls exactly MULT_LAT cycles.
REQ-012 The block SHALL ignore branch_taken, idex_mult and load-use in MISS and MULT; these are re-evaluated in RUN because the pipeline is frozen.
REQ-013 The block SHALL NOT re-trigger mult_start for the same multiply: since idex_en=1 in the release cycle, ID/EX advances.
REQ-014 The block SHALL NOT pulse mult_start more than once per MULT entry.
REQ-015 The block SHALL increment stall_cycles on each posedge where pc_en=0, saturating at 0xFFFF.
REQ-016 The block SHALL compute all outputs combinationally from registered state, counter and current inputs, with no latch inference.

Reset
REQ-017 While rst_n=0, the block SHALL drive pc_en=0, ifid_en=0, idex_en=0, ifid_flush=1, idex_bubble=1 and mult_start=0.
REQ-018 On reset, the block SHALL set state to RUN, the multiply counter to 0 and stall_cycles to 0.
REQ-019 Reset asserted mid-MISS or mid-MULT SHALL abort immediately; after release the block SHALL start in RUN with no mult_start pulse.

Structure
REQ-020 A shared package SHALL hold the state enumeration (RUN=2'd0, MISS=2'd1, MULT=2'd2) and the default MULT_LAT constant.
REQ-021 The load-use comparison SHALL be a sub-module load_use_detect (pure combinational), reusable by the forwarding unit.
REQ-022 The multiply counter SHALL be 6 bits wide, and stall_cycles SHALL be kept in this module.

Verification
REQ-023 Load-use: idex_memread=1, idex_rt=5, id_rs=5 -> one cycle with pc_en=0, idex_bubble=1, idex_en=1, then normal; with idex_rt=0 -> no stall.
REQ-024 Multiply: idex_mult=1 in RUN, MULT_LAT=32 -> mult_start high 1 cycle, enables 0 for 32 cycles, release on cycle 32, stall_cycles=32.
REQ-025 Miss: dcache_hit=0 for 4 cycles -> enables 0 for 5 cycles, then RUN; branch_taken=1 held throughout -> single flush cycle after exit.
REQ-026 Simultaneous: branch_taken=1, idex_mult=1 and load-use together -> flush only, no mult_start; simultaneous icache miss -> MISS wins.
REQ-027 Reset: rst_n low at MULT counter=10 -> outputs go to reset values asynchronously; after release -> RUN, no mult_start, stall_cycles=0.
REQ-028 Saturation: force 70000 stall cycles -> stall_cycles holds at 0xFFFF.
